// File: rtl/ltc2308_pkg.sv
// Shared types and constants for the LTC2308 multi-channel scanner.
// Holds the FSM state enum, config-word fields and the sample type.
package ltc2308_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StConv,
        StWait,
        StShift,
        StDone
    } state_e;

    typedef logic [11:0] sample_t;

    localparam logic CfgSd  = 1'b1;
    localparam logic CfgUni = 1'b1;
    localparam logic CfgSlp = 1'b0;

    // LTC2308 DIN word: SD, O/S, S1, S0, UNI, SLP; O/S is the channel LSB.
    function automatic logic [5:0] cfg_word(input logic [2:0] ch);
        return {CfgSd, ch[0], ch[2], ch[1], CfgUni, CfgSlp};
    endfunction

endpackage

// File: rtl/ltc2308_chan_det.sv
// Per-channel hysteresis comparator and activity timeout for one scanned channel.
// Updates only on a sample strobe addressed to this channel.
module ltc2308_chan_det
    import ltc2308_pkg::*;
#(
    parameter sample_t     HIST_HIGH   = 12'h880,
    parameter sample_t     HIST_LOW    = 12'h780,
    parameter int unsigned ACT_TIMEOUT = 4096
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    upd_i,
    input  sample_t sample_i,
    output logic    dout_o,
    output logic    active_o
);

    localparam int unsigned CntW = $clog2(ACT_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(ACT_TIMEOUT);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    logic            dout_q, dout_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dout_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            dout_q <= dout_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        dout_d = dout_q;
        cnt_d  = cnt_q;
        if (upd_i) begin
            // Samples exactly on a threshold fall in the hold band.
            if (sample_i > HIST_HIGH) begin
                dout_d = 1'b1;
            end else if (sample_i < HIST_LOW) begin
                dout_d = 1'b0;
            end
            if (dout_d != dout_q) begin
                cnt_d = CntLoad;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CntOne;
            end
        end
    end

    assign dout_o   = dout_q;
    assign active_o = (cnt_q != '0);

endmodule

// File: rtl/ltc2308_multi.sv
// LTC2308 round-robin scanner: rate divider, CONVST/SPI sequencer and per-channel detectors.
// Data read in a transfer belongs to the channel configured by the transfer before it.
module ltc2308_multi
    import ltc2308_pkg::*;
#(
    parameter int unsigned CLK_RATE    = 50000000,
    parameter int unsigned ADC_RATE    = 96000,
    parameter int unsigned NUM_CH      = 1,
    parameter int unsigned SCK_DIV     = 2,
    parameter int unsigned CONV_WAIT   = 80,
    parameter sample_t     HIST_HIGH   = 12'h880,
    parameter sample_t     HIST_LOW    = 12'h780,
    parameter int unsigned ACT_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              adc_convst,
    output logic              adc_sck,
    output logic              adc_sdi,
    input  logic              adc_sdo,
    output sample_t           sample,
    output logic [2:0]        sample_ch,
    output logic              sample_valid,
    output logic [NUM_CH-1:0] dout,
    output logic [NUM_CH-1:0] active,
    output logic              overrun
);

    localparam logic [31:0] DivLast     = 32'(CLK_RATE / ADC_RATE - 1);
    localparam logic [15:0] CntConvLast = 16'd3;
    localparam logic [15:0] CntWaitLast = 16'(CONV_WAIT - 1);
    localparam logic [15:0] SckHalf     = 16'(SCK_DIV);
    localparam logic [15:0] SckLast     = 16'(2 * SCK_DIV - 1);
    localparam logic [2:0]  ChLast      = 3'(NUM_CH - 1);

    state_e      state_q, state_d;
    logic [31:0] div_q, div_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  bit_q, bit_d;
    sample_t     shreg_q, shreg_d;
    sample_t     sample_q, sample_d;
    logic [2:0]  sample_ch_q, sample_ch_d;
    logic [2:0]  cur_ch_q, cur_ch_d;
    logic [2:0]  nxt_ch_q, nxt_ch_d;
    logic        primed_q, primed_d;
    logic        overrun_q, overrun_d;
    logic        tick;
    logic [5:0]  cfg;
    logic [2:0]  sdi_idx;

    assign tick = (div_q == DivLast);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            div_q       <= '0;
            cnt_q       <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            sample_q    <= '0;
            sample_ch_q <= '0;
            cur_ch_q    <= '0;
            nxt_ch_q    <= '0;
            primed_q    <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            sample_q    <= sample_d;
            sample_ch_q <= sample_ch_d;
            cur_ch_q    <= cur_ch_d;
            nxt_ch_q    <= nxt_ch_d;
            primed_q    <= primed_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        sample_d    = sample_q;
        sample_ch_d = sample_ch_q;
        cur_ch_d    = cur_ch_q;
        nxt_ch_d    = nxt_ch_q;
        primed_d    = primed_q;
        div_d       = tick ? '0 : div_q + 32'd1;
        overrun_d   = overrun_q | (tick && (state_q != StIdle));
        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    state_d = StConv;
                    cnt_d   = '0;
                end
            end
            StConv: begin
                if (cnt_q == CntConvLast) begin
                    state_d = StWait;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StWait: begin
                if (cnt_q == CntWaitLast) begin
                    state_d = StShift;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StShift: begin
                // Capture on the clock at which SCK goes high.
                if (cnt_q == SckHalf - 16'd1) begin
                    shreg_d = {shreg_q[10:0], adc_sdo};
                end
                if (cnt_q == SckLast) begin
                    cnt_d = '0;
                    if (bit_q == 4'd11) begin
                        state_d = StDone;
                        if (primed_q) begin
                            sample_d    = shreg_q;
                            sample_ch_d = cur_ch_q;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StDone: begin
                state_d  = StIdle;
                primed_d = 1'b1;
                cur_ch_d = nxt_ch_q;
                nxt_ch_d = (nxt_ch_q == ChLast) ? 3'd0 : nxt_ch_q + 3'd1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cfg          = cfg_word(nxt_ch_q);
        sdi_idx      = 3'd5 - bit_q[2:0];
        adc_convst   = (state_q == StConv);
        adc_sck      = (state_q == StShift) && (cnt_q >= SckHalf);
        adc_sdi      = (state_q == StShift) && (bit_q < 4'd6) && cfg[sdi_idx];
        sample_valid = (state_q == StDone) && primed_q;
    end

    assign sample    = sample_q;
    assign sample_ch = sample_ch_q;
    assign overrun   = overrun_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        ltc2308_chan_det #(
            .HIST_HIGH   (HIST_HIGH),
            .HIST_LOW    (HIST_LOW),
            .ACT_TIMEOUT (ACT_TIMEOUT)
        ) u_det (
            .clk_i    (clk),
            .rst_ni   (reset_n),
            .upd_i    (sample_valid && (sample_ch_q == 3'(g))),
            .sample_i (sample_q),
            .dout_o   (dout[g]),
            .active_o (active[g])
        );
    end

endmodule

// File: tb/tb_ltc2308_multi.sv
// Bench for ltc2308_multi: an LTC2308 SDO model answering per configured channel,
// plus a second instance with a tick period shorter than one conversion.
module tb_ltc2308_multi;

    localparam int unsigned NUM_CH      = 2;
    localparam int unsigned SCK_DIV     = 2;
    localparam int unsigned CONV_WAIT   = 8;
    localparam int unsigned ACT_TIMEOUT = 4;
    localparam logic [11:0] HH          = 12'h880;
    localparam logic [11:0] HL          = 12'h780;
    localparam int          ConvCycles  = 4 + CONV_WAIT + 24 * SCK_DIV + 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        adc_convst, adc_sck, adc_sdi, adc_sdo;
    logic [11:0] sample;
    logic [2:0]  sample_ch;
    logic        sample_valid;
    logic [1:0]  dout, active;
    logic        overrun;

    logic        f_convst, f_sck, f_sdi, f_valid, f_overrun;
    logic [11:0] f_sample;
    logic [2:0]  f_sample_ch;
    logic [1:0]  f_dout, f_active;

    int n_assert = 0;
    int n_fail   = 0;

    // ADC model state
    logic [11:0] cur_val [NUM_CH];
    logic [11:0] sdo_word = '0;
    logic [3:0]  sdo_idx  = 4'd11;
    assign adc_sdo = sdo_word[sdo_idx];

    always #5 clk = ~clk;

    ltc2308_multi #(
        .CLK_RATE(1000000), .ADC_RATE(10000), .NUM_CH(NUM_CH), .SCK_DIV(SCK_DIV),
        .CONV_WAIT(CONV_WAIT), .HIST_HIGH(HH), .HIST_LOW(HL), .ACT_TIMEOUT(ACT_TIMEOUT)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .adc_convst(adc_convst), .adc_sck(adc_sck),
        .adc_sdi(adc_sdi), .adc_sdo(adc_sdo), .sample(sample), .sample_ch(sample_ch),
        .sample_valid(sample_valid), .dout(dout), .active(active), .overrun(overrun)
    );

    ltc2308_multi #(
        .CLK_RATE(1000000), .ADC_RATE(20000), .NUM_CH(NUM_CH), .SCK_DIV(SCK_DIV),
        .CONV_WAIT(CONV_WAIT), .HIST_HIGH(HH), .HIST_LOW(HL), .ACT_TIMEOUT(ACT_TIMEOUT)
    ) u_fast (
        .clk(clk), .reset_n(reset_n), .adc_convst(f_convst), .adc_sck(f_sck),
        .adc_sdi(f_sdi), .adc_sdo(1'b0), .sample(f_sample), .sample_ch(f_sample_ch),
        .sample_valid(f_valid), .dout(f_dout), .active(f_active), .overrun(f_overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] cfg_of(input int ch);
        logic [2:0] c;
        c = 3'(ch);
        return {1'b1, c[0], c[2], c[1], 1'b1, 1'b0};
    endfunction

    // Wait for a sample strobe of channel ch (ch < 0: any channel), bounded.
    task automatic wait_sample(input int ch);
        int  n   = 0;
        bit  got = 1'b0;
        while (n < 2000 && !got) begin
            @(negedge clk);
            n++;
            if (sample_valid && (ch < 0 || sample_ch == 3'(ch))) got = 1'b1;
        end
        check("sample_wait", 32'(got), 32'd1);
    endtask

    // Protocol monitor and reference model for the main instance
    logic        p_sck = 1'b0, p_sdi = 1'b0, p_convst = 1'b0;
    int          rise_cnt, fall_cnt, xfer_cnt, conv_w, since_cf, hi_w;
    logic [11:0] sdi_word;
    int          mux_ch;
    bit          pend;
    bit          exp_dout [NUM_CH];
    int          exp_cnt  [NUM_CH];

    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            rise_cnt = 0; fall_cnt = 0; xfer_cnt = 0; conv_w = 0; since_cf = 0; hi_w = 0;
            sdi_word = '0; mux_ch = 0; pend = 1'b0;
            p_sck = 1'b0; p_sdi = 1'b0; p_convst = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                exp_dout[c] = 1'b0;
                exp_cnt[c]  = 0;
            end
        end else begin
            if (pend) begin
                pend = 1'b0;
                check("dout", 32'(dout), 32'({exp_dout[1], exp_dout[0]}));
                check("active", 32'(active), 32'({exp_cnt[1] != 0, exp_cnt[0] != 0}));
            end
            if (adc_convst && !p_convst) begin
                sdo_word = cur_val[mux_ch];
                sdo_idx  = 4'd11;
                rise_cnt = 0; fall_cnt = 0; sdi_word = '0; conv_w = 0;
            end
            if (adc_convst) conv_w++;
            if (!adc_convst && p_convst) begin
                check("convst_width", 32'(conv_w), 32'd4);
                since_cf = 0;
            end else begin
                since_cf++;
            end
            if (adc_sck && !p_sck) begin
                if (rise_cnt == 0) check("wait_len", 32'(since_cf), 32'(CONV_WAIT + SCK_DIV));
                sdi_word = {sdi_word[10:0], adc_sdi};
                rise_cnt++;
                hi_w = 0;
            end
            if (adc_sck) hi_w++;
            if (!adc_sck && p_sck) begin
                check("sck_high", 32'(hi_w), 32'(SCK_DIV));
                fall_cnt++;
                if (sdo_idx != 4'd0) sdo_idx = sdo_idx - 4'd1;
                if (fall_cnt == 12) begin
                    check("sdi_word", 32'(sdi_word), 32'({cfg_of(xfer_cnt % NUM_CH), 6'b0}));
                    mux_ch = int'({sdi_word[9], sdi_word[8], sdi_word[10]}) % NUM_CH;
                    check("valid", 32'(sample_valid), 32'(xfer_cnt >= 1));
                    if (xfer_cnt >= 1) begin
                        int  ch;
                        bit  old;
                        ch = (xfer_cnt - 1) % NUM_CH;
                        check("sample", 32'(sample), 32'(sdo_word));
                        check("sample_ch", 32'(sample_ch), 32'(ch));
                        old = exp_dout[ch];
                        if (sdo_word > HH) exp_dout[ch] = 1'b1;
                        else if (sdo_word < HL) exp_dout[ch] = 1'b0;
                        if (exp_dout[ch] != old) exp_cnt[ch] = ACT_TIMEOUT;
                        else if (exp_cnt[ch] > 0) exp_cnt[ch]--;
                        pend = 1'b1;
                    end
                    xfer_cnt++;
                end
            end else if (sample_valid) begin
                check("valid_spurious", 32'(sample_valid), 32'd0);
            end
            if (adc_sdi != p_sdi) check("sdi_sck_low", 32'(adc_sck), 32'd0);
            p_sck = adc_sck; p_sdi = adc_sdi; p_convst = adc_convst;
        end
    end

    // Fast instance: conversions must never restart mid-transfer
    int f_gap;
    bit f_seen;
    logic f_pconv;
    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            f_gap = 0; f_seen = 1'b0; f_pconv = 1'b0;
        end else begin
            if (f_convst && !f_pconv) begin
                if (f_seen) check("fast_gap", 32'(f_gap > ConvCycles), 32'd1);
                f_gap = 0;
                f_seen = 1'b1;
            end else begin
                f_gap++;
            end
            f_pconv = f_convst;
        end
    end

    initial begin
        int  cnt;
        bit  psck;
        bit  found;
        logic [11:0] seq_v [4];
        bit          seq_d [4];

        cur_val[0] = 12'hC00;
        cur_val[1] = 12'h100;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sample", 32'(sample), 32'd0);
        check("rst_sample_ch", 32'(sample_ch), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_pins", 32'({adc_convst, adc_sck, adc_sdi}), 32'd0);
        check("rst_fast_overrun", 32'(f_overrun), 32'd0);
        reset_n = 1'b1;

        wait_sample(-1);
        check("first_sample_ch", 32'(sample_ch), 32'd0);
        repeat (6) wait_sample(-1);
        @(negedge clk);
        check("dout_01", 32'(dout), 32'd1);

        seq_v = '{12'h900, 12'h800, 12'h780, 12'h700};
        seq_d = '{1'b1, 1'b1, 1'b1, 1'b0};
        wait_sample(0);
        for (int i = 0; i < 4; i++) begin
            cur_val[0] = seq_v[i];
            wait_sample(0);
            @(negedge clk);
            check("hyst_seq", 32'(dout[0]), 32'(seq_d[i]));
        end

        for (int i = 0; i < 4; i++) begin
            cur_val[0] = (i % 2 == 0) ? 12'h900 : 12'h700;
            wait_sample(0);
        end
        @(negedge clk);
        check("act_toggling", 32'(active[0]), 32'd1);
        cur_val[0] = 12'h900;
        wait_sample(0);
        @(negedge clk);
        check("act_reload", 32'(active[0]), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            wait_sample(0);
            @(negedge clk);
            check("act_decay", 32'(active[0]), 32'(k < 4));
        end

        for (int i = 0; i < 12; i++) begin
            cur_val[0] = 12'($urandom_range(32'h700, 32'h900));
            cur_val[1] = 12'($urandom_range(0, 4095));
            wait_sample(0);
        end
        check("no_overrun", 32'(overrun), 32'd0);
        check("fast_overrun", 32'(f_overrun), 32'd1);

        cnt = 0; psck = 1'b0; found = 1'b0;
        for (int n = 0; n < 400 && !found; n++) begin
            @(negedge clk);
            if (adc_convst) cnt = 0;
            if (adc_sck && !psck) cnt++;
            psck = adc_sck;
            if (cnt == 6) found = 1'b1;
        end
        check("sck6_found", 32'(found), 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_pins", 32'({adc_convst, adc_sck}), 32'd0);
        check("abort_valid", 32'(sample_valid), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wait_sample(-1);
        check("resume_ch", 32'(sample_ch), 32'd0);
        repeat (4) wait_sample(-1);
        check("fast_overrun_again", 32'(f_overrun), 32'd1);
        check("no_overrun_end", 32'(overrun), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ltc2308_multi.md
LTC2308_MULTI -- requirements
Module: ltc2308_multi

Interface
REQ-001 SHALL have parameter CLK_RATE, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter ADC_RATE, default 96000, total conversions per second across all channels.
REQ-003 SHALL have parameter NUM_CH, default 1, number of channels scanned, range 1..8.
REQ-004 SHALL have parameter SCK_DIV, default 2, clocks per SCK half-period, minimum 1.
REQ-005 SHALL have parameter CONV_WAIT, default 80, clocks from CONVST fall to first SCK.
REQ-006 SHALL have parameters HIST_HIGH, default 12'h880, and HIST_LOW, default 12'h780, comparator thresholds.
REQ-007 SHALL have parameter ACT_TIMEOUT, default 4096, per-channel samples without a toggle before the channel goes inactive.
REQ-008 SHALL have port clk, input, 1, system clock.
REQ-009 SHALL have port reset_n, input, 1, reset; one clock, and reset is asynchronous and active-low.
REQ-010 SHALL have ports adc_convst, adc_sck and adc_sdi, each output, 1, LTC2308 convert start, serial clock and config data in.
REQ-011 SHALL have port adc_sdo, input, 1, LTC2308 serial data out.
REQ-012 SHALL have port sample, output, 12, last valid conversion result.
REQ-013 SHALL have port sample_ch, output, 3, channel of sample.
REQ-014 SHALL have port sample_valid, output, 1, one-clock strobe when sample and sample_ch update.
REQ-015 SHALL have port dout, output, NUM_CH, hysteresis comparator bit per channel.
REQ-016 SHALL have port active, output, NUM_CH, tape-activity flag per channel.
REQ-017 SHALL have port overrun, output, 1, sticky flag set when a rate tick is dropped.

Function
REQ-018 SHALL generate a rate tick every CLK_RATE/ADC_RATE clocks from a free-running integer divider; the divider wraps to 0 on the tick.
REQ-019 SHALL run the FSM IDLE -> CONV -> WAIT -> SHIFT -> DONE -> IDLE, leaving IDLE only on a tick.
REQ-020 CONV SHALL hold adc_convst high for exactly 4 clocks; adc_convst SHALL be low in every other state.
REQ-021 WAIT SHALL last CONV_WAIT clocks with adc_sck low.
REQ-022 SHIFT SHALL issue exactly 12 SCK periods of 2*SCK_DIV clocks, with SCK idling low.
REQ-023 During SHIFT, SDO SHALL be sampled on the clock where SCK rises, MSB first; adc_sdi SHALL change only while SCK is low.
REQ-024 The first 6 SCK periods SHALL shift out config word {1, nxt[0], nxt[2], nxt[1], 1, 0} MSB first (single-ended, unipolar, no sleep), where nxt is the channel for the following conversion; adc_sdi SHALL be 0 for bits 7..12.
REQ-025 Channel order SHALL be round-robin 0..NUM_CH-1, wrapping to 0.
REQ-026 Data read during a transfer belongs to the channel configured in the previous transfer; sample_ch SHALL report that channel.
REQ-027 The first transfer after reset SHALL produce no sample_valid, because its data is invalid.
REQ-028 DONE SHALL last one clock and assert sample_valid with the updated sample and sample_ch in that same clock.
REQ-029 A tick arriving outside IDLE SHALL be dropped and SHALL set overrun; overrun clears only on reset.
REQ-030 Each sample_valid SHALL update only dout[sample_ch]: set if sample > HIST_HIGH, clear if sample < HIST_LOW, otherwise hold; values equal to a threshold hold.
REQ-031 Activity tracking: on each dout[ch] toggle, the channel counter SHALL reload to ACT_TIMEOUT; on each non-toggling sample of that channel it SHALL decrement, saturating at 0; active[ch] = (counter != 0).

Reset
REQ-032 While reset_n is low: all outputs 0, FSM in IDLE, divider 0, next channel 0, priming flag cleared, activity counters 0.
REQ-033 Reset asserted mid-SHIFT SHALL abort the transfer immediately with no sample_valid; after release the first transfer is again discarded.

Structure
REQ-034 Package ltc2308_pkg SHALL hold the FSM state enum, the config-word bit constants (SD=1, UNI=1, SLP=0) and the 12-bit sample typedef.
REQ-035 Per-channel hysteresis and activity logic SHALL be a sub-module ltc2308_chan_det, instantiated NUM_CH times by generate.

Verification
REQ-036 Configuration NUM_CH=2; SDO model returns 12'hC00 for ch0 and 12'h100 for ch1 -> SDI words 6'b100010 / 6'b110010 alternate; sample_ch alternates 0,1; dout becomes 2'b01.
REQ-037 After reset -> the first transfer produces no sample_valid; the second produces sample_valid with sample_ch=0.
REQ-038 ch0 value sequence 12'h900, 12'h800, 12'h780, 12'h700 -> dout[0] sequence 1, 1, 1, 0.
REQ-039 ACT_TIMEOUT=4 with alternating 12'h900/12'h700 -> active=1; then constant 12'h900 -> active falls after exactly 4 non-toggling samples.
REQ-040 ADC_RATE set so the tick period is below the conversion time -> overrun=1 and the FSM is never re-entered mid-transfer.
REQ-041 reset_n pulsed low at the 6th SCK -> adc_convst and adc_sck go low at once, no sample_valid, and conversion resumes at channel 0.
